// File: rtl/cordic_arbiter_pkg.sv
// Shared types and helpers for the round-robin CORDIC arbiter: FSM state
// encoding, the quiet-NaN error result and the round-robin selection function.
package cordic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic [31:0] QNAN_F32 = 32'h7FC0_0000;
  localparam int          MAX_REQ  = 8;
  localparam int          ID_W     = 3;

  // First set request strictly after `last`, wrapping modulo n; 0 when none set.
  function automatic logic [ID_W-1:0] rr_next(input logic [MAX_REQ-1:0] req,
                                              input logic [ID_W-1:0]    last,
                                              input int                 n);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = {ID_W{1'b0}};
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((k <= n) && !found && req[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester-side and core-side signals of the CORDIC arbiter; the arbiter uses
// the slave view, the surrounding front ends and core wrapper the master view.
interface cordic_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0][31:0] arg;
  logic [N_REQ-1:0]       ack;
  logic [31:0]            result;
  logic                   result_err;
  logic                   busy;
  logic                   core_clk_en;
  logic                   core_start;
  logic [31:0]            core_x_ft;
  logic                   core_done;
  logic [31:0]            core_y_ft;

  modport slave (
    input  req, arg, core_done, core_y_ft,
    output ack, result, result_err, busy, core_clk_en, core_start, core_x_ft
  );

  modport master (
    output req, arg, core_done, core_y_ft,
    input  ack, result, result_err, busy, core_clk_en, core_start, core_x_ft
  );
endinterface

// File: rtl/cordic_arbiter_rr_picker.sv
// Combinational round-robin picker: next requester after the last grant.
module rr_picker
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last_grant,
  output logic [IDX_W-1:0] o_grant_id,
  output logic             o_any_req
);
  logic [ID_W-1:0] w_pick;

  assign w_pick     = rr_next(MAX_REQ'(i_req), ID_W'(i_last_grant), N_REQ);
  assign o_grant_id = IDX_W'(w_pick);
  assign o_any_req  = |i_req;
endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cosine core among N_REQ requesters: round-robin grant, one
// operation at a time, watchdog abort with a quiet-NaN error result.
module cordic_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  cordic_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE_HOT = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_id;
  logic [IDX_W-1:0] r_last;
  logic [WD_W-1:0]  r_wd;
  logic [31:0]      r_x;
  logic [31:0]      r_result;
  logic             r_err;
  logic [N_REQ-1:0] r_ack;
  logic             r_start;
  logic             r_busy;
  logic             r_clk_en;
  logic [IDX_W-1:0] w_grant_id;
  logic             w_any_req;

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req        (bus.req),
    .i_last_grant (r_last),
    .o_grant_id   (w_grant_id),
    .o_any_req    (w_any_req)
  );

  // Arbitration FSM; the watchdog value 0 marks the first WAIT cycle, where a
  // done level left over from an earlier operation must not be trusted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_id     <= {IDX_W{1'b0}};
      r_last   <= IDX_W'(N_REQ - 1);
      r_wd     <= {WD_W{1'b0}};
      r_x      <= 32'h0000_0000;
      r_result <= 32'h0000_0000;
      r_err    <= 1'b0;
      r_ack    <= {N_REQ{1'b0}};
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_clk_en <= 1'b0;
    end else begin
      r_clk_en <= 1'b1;
      r_start  <= 1'b0;
      r_ack    <= {N_REQ{1'b0}};
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_id    <= w_grant_id;
            r_x     <= bus.arg[w_grant_id];
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        ISSUE: begin
          r_wd    <= {WD_W{1'b0}};
          r_state <= WAIT;
        end
        WAIT: begin
          r_wd <= r_wd + WD_W'(1);
          if (bus.core_done && (r_wd != {WD_W{1'b0}})) begin
            r_result <= bus.core_y_ft;
            r_err    <= 1'b0;
            r_ack    <= ONE_HOT << r_id;
            r_state  <= RESP;
          end else if (r_wd == WD_LAST) begin
            r_result <= QNAN_F32;
            r_err    <= 1'b1;
            r_ack    <= ONE_HOT << r_id;
            r_state  <= RESP;
          end else begin
            r_state  <= WAIT;
          end
        end
        RESP: begin
          r_last  <= r_id;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = r_ack;
  assign bus.result      = r_result;
  assign bus.result_err  = r_err;
  assign bus.busy        = r_busy;
  assign bus.core_clk_en = r_clk_en;
  assign bus.core_start  = r_start;
  assign bus.core_x_ft   = r_x;
endmodule
